// File: rtl/cdb_arbiter_if.sv
// CDB packet type and the producer/arbiter bus bundle.

package cdb_arbiter_pkg;

    // One result broadcast on the common data bus.
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [31:0] value;
    } cdb_packet_t;

endpackage

interface cdb_arbiter_if #(
    parameter int unsigned N = 6
);
    import cdb_arbiter_pkg::*;

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]             req_valid;
    cdb_packet_t [N-1:0]      req_pkt;
    logic [N-1:0]             yumi_out;
    cdb_packet_t              cdb_out;
    logic                     cdb_valid;
    logic [IW-1:0]            grant_idx;

    // Producer side.
    modport master (
        output req_valid, req_pkt,
        input  yumi_out, cdb_out, cdb_valid, grant_idx
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_pkt,
        output yumi_out, cdb_out, cdb_valid, grant_idx
    );

endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: aged requesters first, then the fixed-priority
// port, then round-robin; the winner's packet is registered onto the CDB.

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N        = 6,
    parameter int unsigned PRIO_IDX = 4,
    parameter int unsigned AGE_MAX  = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] age_q [N];
    logic [AW-1:0] age_d [N];
    logic          cdb_valid_q, cdb_valid_d;
    cdb_packet_t   cdb_out_q, cdb_out_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;

    logic [N-1:0]  aged_c;
    logic [IW:0]   scan_c;
    logic          gnt_c;
    logic [IW-1:0] gnt_idx_c;

    // First set bit of mask scanning ptr, ptr+1, ... wrapping at N; returns {found, idx}.
    function automatic logic [IW:0] rr_scan(input logic [N-1:0] mask, input logic [IW-1:0] ptr);
        logic          found;
        logic [IW-1:0] idx;
        logic [IW:0]   pos;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && mask[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
        return {found, idx};
    endfunction

    // Same-cycle grant selection; nothing is granted during reset or flush.
    always_comb begin
        aged_c = '0;
        scan_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            aged_c[i] = bus.req_valid[i] && (age_q[i] == AGE_SAT);
        end
        if (reset && !flush) begin
            if (|aged_c) begin
                scan_c = rr_scan(aged_c, rr_ptr_q);
            end else if (bus.req_valid[PRIO_IDX]) begin
                scan_c = {1'b1, IW'(PRIO_IDX)};
            end else begin
                scan_c = rr_scan(bus.req_valid, rr_ptr_q);
            end
        end
        gnt_c     = scan_c[IW];
        gnt_idx_c = scan_c[IW-1:0];
    end

    assign bus.yumi_out  = gnt_c ? (N'(1) << gnt_idx_c) : '0;
    assign bus.cdb_out   = cdb_out_q;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.grant_idx = grant_idx_q;

    // Next-state: CDB load, round-robin pointer advance and per-requester aging.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_out_d   = cdb_out_q;
        grant_idx_d = grant_idx_q;
        for (int unsigned i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
        end
        if (flush) begin
            rr_ptr_d = '0;
            for (int unsigned i = 0; i < N; i++) begin
                age_d[i] = '0;
            end
        end else begin
            if (gnt_c) begin
                cdb_valid_d = 1'b1;
                cdb_out_d   = bus.req_pkt[gnt_idx_c];
                grant_idx_d = gnt_idx_c;
                rr_ptr_d    = (gnt_idx_c == IW'(N - 1)) ? '0 : gnt_idx_c + 1'b1;
            end
            for (int unsigned i = 0; i < N; i++) begin
                if ((gnt_c && (gnt_idx_c == IW'(i))) || !bus.req_valid[i]) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AGE_SAT) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_out_q   <= '0;
            grant_idx_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_out_q   <= cdb_out_d;
            grant_idx_q <= grant_idx_d;
            for (int unsigned i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-cycle reference model.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N    = 6;
    localparam int PRIO = 4;
    localparam int AMAX = 7;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N(N)) bus();

    cdb_arbiter #(.N(N), .PRIO_IDX(PRIO), .AGE_MAX(AMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic cdb_packet_t mk(input int rob, input int val);
        cdb_packet_t p;
        p.rob_idx = 6'(rob);
        p.value   = 32'(val);
        return p;
    endfunction

    // Reference model state: what the CDB registers and ages must hold.
    int          m_rr    = 0;
    int          m_age [N];
    bit          m_valid = 1'b0;
    cdb_packet_t m_pkt   = '0;
    int          m_gidx  = 0;

    // Winner under the priority rules for the current inputs, -1 if none.
    function automatic int model_grant();
        if (!reset || flush) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (bus.req_valid[i] && m_age[i] >= AMAX) return i;
        end
        if (bus.req_valid[PRIO]) return PRIO;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    // Compare and advance the model once per cycle, mid-cycle.
    always @(negedge clk) begin : monitor
        int g;
        logic [N-1:0] exp_yumi;
        if (!reset) begin
            m_rr = 0; m_valid = 1'b0; m_pkt = '0; m_gidx = 0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end
        check("m_cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
        check("m_cdb_out", 64'(bus.cdb_out), 64'(m_pkt));
        check("m_grant_idx", 64'(bus.grant_idx), 64'(m_gidx));
        g = model_grant();
        exp_yumi = (g >= 0) ? N'(1) << g : '0;
        check("m_yumi", 64'(bus.yumi_out), 64'(exp_yumi));
        if (reset) begin
            if (flush) begin
                m_valid = 1'b0;
                m_rr = 0;
                for (int i = 0; i < N; i++) m_age[i] = 0;
            end else begin
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_pkt  = bus.req_pkt[g];
                    m_gidx = g;
                    m_rr   = (g + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (i == g || !bus.req_valid[i]) m_age[i] = 0;
                    else m_age[i] = (m_age[i] + 1 > AMAX) ? AMAX : m_age[i] + 1;
                end
            end
        end
    end

    logic [N-1:0] order4 [6];

    initial begin
        for (int i = 0; i < N; i++) m_age[i] = 0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) bus.req_pkt[i] = mk(10 + i, 32'hA000 + i);

        // Held in reset
        repeat (3) @(posedge clk);
        #3;
        check("rst_yumi", 64'(bus.yumi_out), 64'd0);
        check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Idle after reset
        repeat (5) begin
            @(posedge clk); #3;
            check("idle_valid", 64'(bus.cdb_valid), 64'd0);
            check("idle_yumi", 64'(bus.yumi_out), 64'd0);
            check("idle_gidx", 64'(bus.grant_idx), 64'd0);
        end

        // Two round-robin requesters alternate
        @(posedge clk); #1;
        bus.req_pkt[0] = mk(3, 32'h1111);
        bus.req_pkt[1] = mk(5, 32'h2222);
        bus.req_valid  = 6'b000011;
        #2 check("rr2_yumi0", 64'(bus.yumi_out), 64'b000001);
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #3;
            check("rr2_yumi", 64'(bus.yumi_out), (c % 2) ? 64'b000010 : 64'b000001);
            check("rr2_valid", 64'(bus.cdb_valid), 64'd1);
            check("rr2_rob", 64'(bus.cdb_out.rob_idx), (c % 2) ? 64'd3 : 64'd5);
        end
        @(posedge clk); #1 bus.req_valid = '0;
        #2;
        check("rr2_last_rob", 64'(bus.cdb_out.rob_idx), 64'd5);
        check("rr2_last_valid", 64'(bus.cdb_valid), 64'd1);

        // Priority port starves port 0 until it ages out
        @(posedge clk); #1;
        bus.req_pkt[4] = mk(9, 32'h4444);
        bus.req_valid  = 6'b010001;
        #2 check("age_yumi1", 64'(bus.yumi_out), 64'b010000);
        for (int c = 2; c <= 9; c++) begin
            @(posedge clk); #3;
            check("age_yumi", 64'(bus.yumi_out), (c == 8) ? 64'b000001 : 64'b010000);
            if (c == 9) begin
                check("age_rob", 64'(bus.cdb_out.rob_idx), 64'd3);
                check("age_gidx", 64'(bus.grant_idx), 64'd0);
            end
        end

        // Flush to bring the pointer back to 0
        @(posedge clk); #1 bus.req_valid = '0; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;

        // Full round-robin sweep without the priority port
        order4[0] = 6'b000001; order4[1] = 6'b000010; order4[2] = 6'b000100;
        order4[3] = 6'b001000; order4[4] = 6'b100000; order4[5] = 6'b000001;
        bus.req_valid = 6'b101111;
        #2 check("sweep_yumi", 64'(bus.yumi_out), 64'(order4[0]));
        for (int c = 1; c < 6; c++) begin
            @(posedge clk); #3;
            check("sweep_yumi", 64'(bus.yumi_out), 64'(order4[c]));
        end
        @(posedge clk); #1 bus.req_valid = '0;

        // Flush suppresses the grant, next cycle grants port 2
        @(posedge clk); #1 bus.req_valid = 6'b000100; flush = 1'b1;
        #2 check("flush_yumi", 64'(bus.yumi_out), 64'd0);
        @(posedge clk); #1 flush = 1'b0;
        #2;
        check("flush_valid", 64'(bus.cdb_valid), 64'd0);
        check("post_flush_yumi", 64'(bus.yumi_out), 64'b000100);
        @(posedge clk); #1 bus.req_valid = '0;
        #2;
        check("post_flush_valid", 64'(bus.cdb_valid), 64'd1);
        check("post_flush_gidx", 64'(bus.grant_idx), 64'd2);

        // Asynchronous reset mid-stream
        @(posedge clk); #1 bus.req_valid = 6'b000011;
        @(posedge clk); #2;
        check("pre_rst_valid", 64'(bus.cdb_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.cdb_valid), 64'd0);
        check("async_rst_yumi", 64'(bus.yumi_out), 64'd0);
        check("async_rst_gidx", 64'(bus.grant_idx), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #2 check("after_rst_yumi", 64'(bus.yumi_out), 64'b000001);
        repeat (3) @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
